// File: rtl/b1_pkg.sv
// b1 benchmark function: per-lane result record, evaluation helper and reset values.
package b1_pkg;

  // One lane of the b1 result; a WIDTH-lane result is a packed array of these.
  typedef struct packed {
    logic po0;
    logic po1;
    logic po2;
    logic po3;
  } b1_lane_t;

  localparam int       LANE_BITS = $bits(b1_lane_t);
  localparam logic     RST_VALID = 1'b0;
  localparam b1_lane_t RST_LANE  = '0;
  localparam logic     RST_HIT   = 1'b0;

  // Golden b1 equations for a single lane; lanes never interact.
  function automatic b1_lane_t b1_eval(input logic a, input logic b, input logic c);
    b1_lane_t r;
    r.po0 = c;
    r.po1 = a ^ b;
    r.po2 = (a & b & ~c) | (~a & ~b & c);
    r.po3 = ~c;
    return r;
  endfunction

endpackage

// File: rtl/b1_pipe_stage.sv
// One pipeline register: valid bit plus payload, loaded whenever the stage may accept.
module b1_pipe_stage
  import b1_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Payload only changes on a real beat, so it stays zero until the first
  // arrival and holds steady while the stage is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= RST_VALID;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/b1_pipe.sv
// Pipelined, lane-parallel b1 evaluator with valid/ready flow control,
// a wrapping output-handshake counter and a sticky po2-nonzero flag.
module b1_pipe
  import b1_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   pi0,
  input  logic [WIDTH-1:0]   pi1,
  input  logic [WIDTH-1:0]   pi2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   po0,
  output logic [WIDTH-1:0]   po1,
  output logic [WIDTH-1:0]   po2,
  output logic [WIDTH-1:0]   po3,
  input  logic               clear,
  output logic [COUNT_W-1:0] count,
  output logic               hit
);

  localparam int DW = WIDTH * LANE_BITS;

  b1_lane_t [WIDTH-1:0] eval_res;
  b1_lane_t [WIDTH-1:0] out_res;
  logic                 vld_pipe [DEPTH];
  logic                 load     [DEPTH];
  logic [DW-1:0]        dat_pipe [DEPTH];
  logic                 out_fire;

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    assign eval_res[l] = b1_eval(pi0[l], pi1[l], pi2[l]);
    assign po0[l]      = out_res[l].po0;
    assign po1[l]      = out_res[l].po1;
    assign po2[l]      = out_res[l].po2;
    assign po3[l]      = out_res[l].po3;
  end

  // Ready chain, walked from the output back: a stage may load when it is
  // empty or its occupant moves on this cycle. Built in one block so the
  // chain is a plain combinational ripple with no bubbles.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) load[i] = 1'b0;
    load[DEPTH-1] = !vld_pipe[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) load[i] = !vld_pipe[i] || load[i+1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic          up_valid;
    logic [DW-1:0] up_data;
    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = eval_res;
    end else begin : g_body
      assign up_valid = vld_pipe[i-1];
      assign up_data  = dat_pipe[i-1];
    end
    b1_pipe_stage #(.W(DW)) u_stage (
      .clock    (clock),
      .reset    (reset),
      .load     (load[i]),
      .up_valid (up_valid),
      .up_data  (up_data),
      .valid    (vld_pipe[i]),
      .data     (dat_pipe[i])
    );
  end

  // Ready is held low while reset is asserted even though the stages are empty.
  assign in_ready  = !reset && load[0];
  assign out_valid = vld_pipe[DEPTH-1];
  assign out_res   = dat_pipe[DEPTH-1];
  assign out_fire  = out_valid && out_ready;

  // Handshake counter and sticky hit; clear takes priority over a same-cycle beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      hit   <= RST_HIT;
    end else if (clear) begin
      count <= '0;
      hit   <= RST_HIT;
    end else if (out_fire) begin
      count <= count + 1'b1;
      if (|po2) hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_b1_pipe.sv
// Directed bench for b1_pipe (WIDTH=4, DEPTH=2, COUNT_W=3): latency, truth
// table, backpressure, counter wrap, clear priority and mid-flight reset.
module tb_b1_pipe;

  localparam int W  = 4;
  localparam int D  = 2;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  pi0, pi1, pi2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  po0, po1, po2, po3;
  logic          clear;
  logic [CW-1:0] count;
  logic          hit;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [15:0]   exp_q [$];

  b1_pipe #(.WIDTH(W), .DEPTH(D), .COUNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pi0       (pi0),
    .pi1       (pi1),
    .pi2       (pi2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .po0       (po0),
    .po1       (po1),
    .po2       (po2),
    .po3       (po3),
    .clear     (clear),
    .count     (count),
    .hit       (hit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Hand-derived b1 truth table, index = {a,b,c}, value = {po0,po1,po2,po3}.
  function automatic logic [3:0] tv(input int i);
    case (i)
      0: return 4'b0001;
      1: return 4'b1010;
      2: return 4'b0101;
      3: return 4'b1100;
      4: return 4'b0101;
      5: return 4'b1100;
      6: return 4'b0011;
      default: return 4'b1000;
    endcase
  endfunction

  // Present truth-table row i on every lane.
  task automatic drive(input int i);
    logic [2:0] ib;
    ib       = 3'(i);
    pi0      = {W{ib[2]}};
    pi1      = {W{ib[1]}};
    pi2      = {W{ib[0]}};
    in_valid = 1'b1;
  endtask

  task automatic push(input int i);
    logic [3:0] t;
    t = tv(i);
    exp_q.push_back({{W{t[3]}}, {W{t[2]}}, {W{t[1]}}, {W{t[0]}}});
  endtask

  // Check any output beat about to hand off, then advance one clock.
  task automatic tick();
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("stray_beat", 32'(out_valid), 0);
      else                   chk("beat", {po0, po1, po2, po3}, exp_q.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int j;
    bit acc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    pi0 = '0; pi1 = '0; pi2 = '0;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready),  0);
    chk("rst_count",     32'(count),     0);
    chk("rst_hit",       32'(hit),       0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("in_ready_post_rst", 32'(in_ready), 1);
    chk("idle_outs_zero",    {po0, po1, po2, po3}, 0);

    // Single beat, latency of DEPTH edges
    pi0 = 4'b1100; pi1 = 4'b1010; pi2 = 4'b0110; in_valid = 1'b1;
    exp_q.push_back(16'b0110_0110_1000_1001);
    tick();
    in_valid = 1'b0;
    chk("lat_edge1", 32'(out_valid), 0);
    tick();
    chk("lat_edge2", 32'(out_valid), 1);
    tick();
    chk("t1_count", 32'(count), 1);
    chk("t1_hit",   32'(hit),   1);

    // All 8 combinations back-to-back, no bubbles; 1+8 handshakes wrap to 1
    for (int i = 0; i < 8; i++) begin
      drive(i); push(i);
      tick();
      if (i >= 1) chk("no_bubble", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("wrap_count", 32'(count), 1);
    chk("drained", 32'(exp_q.size()), 0);

    // clear coincident with a po2!=0 handshake wins
    drive(6); push(6);
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_pre_valid", 32'(out_valid), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_count", 32'(count), 0);
    chk("clr_hit",   32'(hit),   0);
    drive(0); push(0);
    tick(); in_valid = 1'b0; tick(); tick();
    chk("po2zero_count", 32'(count), 1);
    chk("po2zero_hit",   32'(hit),   0);
    drive(1); push(1);
    tick(); in_valid = 1'b0; tick(); tick();
    chk("hit_set_count", 32'(count), 2);
    chk("hit_set",       32'(hit),   1);

    // Backpressure: 6 beats, out_ready low for 5 cycles
    clear = 1'b1; tick(); clear = 1'b0;
    j = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = (cyc >= 5);
      if (j < 6) drive(j + 2);
      else       in_valid = 1'b0;
      #1;
      if (cyc >= 2 && cyc <= 4) chk("bp_full", 32'(in_ready), 0);
      if (cyc == 4)             chk("bp_hold", {po0, po1, po2, po3}, exp_q[0]);
      if (cyc == 5)             chk("bp_release", 32'(in_ready), 1);
      acc = in_valid && in_ready;
      if (acc) push(j + 2);
      tick();
      if (acc) j++;
    end
    in_valid = 1'b0;
    chk("bp_sent",    32'(j), 6);
    chk("bp_drained", 32'(exp_q.size()), 0);
    chk("bp_count",   32'(count), 6);
    chk("bp_hit",     32'(hit), 1);

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive(1);
    tick(); tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready),  0);
    chk("mid_rst_count", 32'(count),     0);
    chk("mid_rst_hit",   32'(hit),       0);
    @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("no_stale", 32'(out_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
